// File: rtl/dot_product_mac.sv
// dot_product_mac
//   Streaming fixed-point dot-product engine. Takes LANES value/weight pairs
//   per accepted beat and accumulates VEC_LEN products. Emits one saturated
//   DATA_W-bit result (FRAC_W fractional bits) per vector.
//
//   Pipeline: S1 lane products -> S2 lane sum -> S3 accumulator -> S4 output.
//   The accumulator loads the sum of beat 0, so vectors can follow back to back.
//
//   Optional feature macro: DOT_RELU_EN (fuse ReLU: negative results -> 0).
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high; clears all state
//   in_valid   beat available
//   in_ready   engine accepts a beat (from FSM state only)
//   in_values  LANES x DATA_W signed values, lane k at [k*DATA_W +: DATA_W]
//   in_weights LANES x DATA_W signed weights, same packing
//   out_valid  result available (held until out_ready)
//   out_ready  consumer takes result
//   out_data   signed saturated result
//   out_sat    result was clipped by saturation
module dot_product_mac #(
    parameter int DATA_W  = 16,
    parameter int FRAC_W  = 8,
    parameter int LANES   = 16,
    parameter int VEC_LEN = 784
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DATA_W-1:0]   in_values,
    input  logic [LANES*DATA_W-1:0]   in_weights,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_sat
);

    localparam int BEATS  = VEC_LEN / LANES;
    localparam int PROD_W = 2 * DATA_W;
    localparam int ACC_W  = 2 * DATA_W + $clog2(VEC_LEN);
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic signed [ACC_W-1:0] RES_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] RES_MIN =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    generate
        if ((VEC_LEN % LANES) != 0) begin : g_bad_vec_len
            $error("dot_product_mac: VEC_LEN must be a multiple of LANES");
        end
        if ((LANES < 2) || ((LANES & (LANES - 1)) != 0)) begin : g_bad_lanes
            $error("dot_product_mac: LANES must be a power of two >= 2");
        end
    endgenerate

    logic [1:0]              state;
    logic [1:0]              state_nxt;
    logic [CNT_W-1:0]        beat_cnt;
    logic                    beat_last;
    logic                    accept;

    logic signed [PROD_W-1:0] prod_c [LANES];
    logic signed [PROD_W-1:0] s1_prod [LANES];
    logic                     s1_v, s1_first, s1_last;

    logic signed [ACC_W-1:0]  lane_sum;
    logic signed [ACC_W-1:0]  s2_sum;
    logic                     s2_v, s2_first, s2_last;

    logic signed [ACC_W-1:0]  acc;
    logic                     s3_v, s3_last;

    logic signed [ACC_W-1:0]  acc_shift;
    logic [DATA_W-1:0]        res_c;
    logic                     sat_c;

    assign in_ready  = (state == ST_IDLE) || (state == ST_ACCUM);
    assign out_valid = (state == ST_HOLD);
    assign accept    = in_valid && in_ready;
    assign beat_last = (beat_cnt == CNT_W'(BEATS - 1));

    // Per-lane signed products, operands sign-extended to full product width.
    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) begin
            prod_c[i] = PROD_W'($signed(in_values[i*DATA_W +: DATA_W]))
                      * PROD_W'($signed(in_weights[i*DATA_W +: DATA_W]));
        end
    end

    always_comb begin
        lane_sum = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_sum = lane_sum
                     + {{(ACC_W-PROD_W){s1_prod[i][PROD_W-1]}}, s1_prod[i]};
        end
    end

    // Floor to integer format, then clip to the DATA_W signed range.
    always_comb begin
        acc_shift = acc >>> FRAC_W;
        sat_c     = 1'b0;
        if (acc_shift > RES_MAX) begin
            res_c = RES_MAX[DATA_W-1:0];
            sat_c = 1'b1;
        end else if (acc_shift < RES_MIN) begin
            res_c = RES_MIN[DATA_W-1:0];
            sat_c = 1'b1;
        end else begin
            res_c = acc_shift[DATA_W-1:0];
        end
`ifdef DOT_RELU_EN
        if (res_c[DATA_W-1]) begin
            res_c = '0;
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = beat_last ? ST_DRAIN : ST_ACCUM;
            ST_ACCUM: if (accept && beat_last) state_nxt = ST_DRAIN;
            ST_DRAIN: if (s3_v && s3_last) state_nxt = ST_HOLD;
            ST_HOLD:  if (out_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            beat_cnt <= '0;
            s1_v     <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            for (int unsigned i = 0; i < LANES; i++) begin
                s1_prod[i] <= '0;
            end
            s2_v     <= 1'b0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
            s2_sum   <= '0;
            s3_v     <= 1'b0;
            s3_last  <= 1'b0;
            acc      <= '0;
            out_data <= '0;
            out_sat  <= 1'b0;
        end else begin
            state <= state_nxt;

            if (accept) begin
                beat_cnt <= beat_last ? '0 : beat_cnt + 1'b1;
            end

            // S1: products, tagged with first/last-beat markers
            s1_v     <= accept;
            s1_first <= accept && (beat_cnt == '0);
            s1_last  <= accept && beat_last;
            if (accept) begin
                for (int unsigned i = 0; i < LANES; i++) begin
                    s1_prod[i] <= prod_c[i];
                end
            end

            // S2: lane sum
            s2_v     <= s1_v;
            s2_first <= s1_first;
            s2_last  <= s1_last;
            if (s1_v) begin
                s2_sum <= lane_sum;
            end

            // S3: accumulator; beat 0 loads instead of adding
            s3_v    <= s2_v;
            s3_last <= s2_v && s2_last;
            if (s2_v) begin
                acc <= s2_first ? s2_sum : acc + s2_sum;
            end

            // S4: output register, loaded once per vector and held in HOLD
            if (s3_v && s3_last) begin
                out_data <= res_c;
                out_sat  <= sat_c;
            end
        end
    end

endmodule

// File: tb/tb_dot_product_mac.sv
module tb_dot_product_mac;

    localparam int DW = 16;
    localparam int LN = 16;
    localparam int VL = 784;
    localparam int BT = VL / LN;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [LN*DW-1:0]  in_values;
    logic [LN*DW-1:0]  in_weights;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic              out_sat;

    int cyc   = 0;
    int n_cmp = 0;
    int n_err = 0;

    logic signed [DW-1:0] vals [VL];
    logic signed [DW-1:0] wts  [VL];

    dot_product_mac #(
        .DATA_W (16),
        .FRAC_W (8),
        .LANES  (LN),
        .VEC_LEN(VL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_values (in_values),
        .in_weights(in_weights),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: exact integer dot product, floor divide by 2^8, clip, optional ReLU.
    task automatic model(output logic [DW-1:0] res, output logic sat);
        longint acc;
        longint q;
        acc = 0;
        for (int i = 0; i < VL; i++) begin
            acc += longint'(vals[i]) * longint'(wts[i]);
        end
        q   = acc >>> 8;
        sat = 1'b0;
        if (q > 32767) begin
            q = 32767;
            sat = 1'b1;
        end else if (q < -32768) begin
            q = -32768;
            sat = 1'b1;
        end
`ifdef DOT_RELU_EN
        if (q < 0) q = 0;
`endif
        res = q[DW-1:0];
    endtask

    task automatic fill(input logic [DW-1:0] v, input logic [DW-1:0] w);
        for (int i = 0; i < VL; i++) begin
            vals[i] = v;
            wts[i]  = w;
        end
    endtask

    task automatic fill_rand(input int mode);
        for (int i = 0; i < VL; i++) begin
            if (mode == 0) begin
                vals[i] = DW'($urandom_range(0, 1023)) - 16'sd512;
                wts[i]  = DW'($urandom_range(0, 511)) - 16'sd256;
            end else begin
                vals[i] = DW'($urandom);
                wts[i]  = DW'($urandom);
            end
        end
    endtask

    // Offer nbeats beats; returns the cycle stamps of the first and last accepting edges.
    task automatic stream(input int nbeats, input bit toggle, output int first_c, output int last_c);
        int b;
        int guard;
        bit phase;
        bit fire;
        b = 0;
        guard = 0;
        phase = 1'b1;
        first_c = -1;
        last_c = -1;
        while (b < nbeats && guard < 4 * nbeats + 20) begin
            in_valid = toggle ? phase : 1'b1;
            for (int k = 0; k < LN; k++) begin
                in_values[k*DW +: DW]  = vals[b*LN + k];
                in_weights[k*DW +: DW] = wts[b*LN + k];
            end
            fire = in_valid && in_ready;
            @(posedge clk);
            #1;
            guard++;
            phase = ~phase;
            if (fire) begin
                if (b == 0) first_c = cyc;
                last_c = cyc;
                b++;
            end
        end
        in_valid = 1'b0;
        if (b < nbeats) check("stream_timeout", b, nbeats);
    endtask

    task automatic finish_vec(input string tag, input int hold_n, input bit tput, input int first_c);
        logic [DW-1:0] er;
        logic          es;
        logic [DW-1:0] d0;
        int k;
        model(er, es);
        out_ready = (hold_n == 0);
        k = 0;
        while (!out_valid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({tag, "_latency"}, k, 3);
        if (out_valid) begin
            check({tag, "_data"}, out_data, er);
            check({tag, "_sat"}, out_sat, es);
            check({tag, "_ready_in_hold"}, in_ready, 1'b0);
            d0 = out_data;
            for (int h = 0; h < hold_n; h++) begin
                @(posedge clk);
                #1;
                check({tag, "_hold_valid"}, out_valid, 1'b1);
                check({tag, "_hold_data"}, out_data, d0);
                check({tag, "_hold_ready"}, in_ready, 1'b0);
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            check({tag, "_valid_drop"}, out_valid, 1'b0);
            check({tag, "_idle_ready"}, in_ready, 1'b1);
            if (tput) check({tag, "_throughput"}, cyc - first_c, BT + 3);
        end
    endtask

    task automatic run_vec(input string tag, input bit toggle, input int hold_n);
        int fc;
        int lc;
        stream(BT, toggle, fc, lc);
        finish_vec(tag, hold_n, !toggle && hold_n == 0, fc);
    endtask

    initial begin
        int fc;
        int lc;
        int seen;
        reset      = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        in_values  = '0;
        in_weights = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 16'h0000);
        check("rst_out_sat", out_sat, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        fill(16'h0100, 16'h0010);
        run_vec("pos_basic", 1'b0, 0);
        fill(16'h0100, 16'hFFF0);
        run_vec("neg_basic", 1'b0, 0);
        fill(16'h0100, 16'h0100);
        run_vec("sat_pos", 1'b0, 0);
        fill(16'hFF00, 16'h0100);
        run_vec("sat_neg", 1'b0, 0);
        fill(16'h0100, 16'h0010);
        run_vec("toggle_hold", 1'b1, 5);

        // Abort a vector after beat 20; the next vector must be unaffected.
        fill(16'h0100, 16'h0010);
        stream(21, 1'b0, fc, lc);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_out_data", out_data, 16'h0000);
        reset = 1'b0;
        @(posedge clk);
        #1;
        run_vec("after_rst", 1'b0, 0);
        seen = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("after_rst_single", seen, 0);

        fill_rand(0);
        run_vec("b2b_first", 1'b0, 0);
        fill(16'h0200, 16'h0010);
        run_vec("b2b_second", 1'b0, 0);

        for (int i = 0; i < 6; i++) begin
            fill_rand(i % 2);
            run_vec($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dot_product_mac.md
# dot_product_mac

Streaming, parametrised fixed-point dot-product engine that replaces the fully parallel single-vector calculator in the neuron layer. It accepts LANES value/weight pairs per beat over a valid/ready handshake and accumulates VEC_LEN products. It emits one saturated fixed-point result per vector. It sits between the activation/weight fetch buffers and the layer output buffer, trading throughput for area.

## Interface
- DATA_W, 16: signed operand and result width (two's complement).
- FRAC_W, 8: fractional bits of operands and result (Q8.8 by default).
- LANES, 16: value/weight pairs consumed per accepted beat; power of two, ≥2.
- VEC_LEN, 784: elements per vector; must be a multiple of LANES (elaboration error otherwise).
- Derived: BEATS = VEC_LEN/LANES; ACC_W = 2*DATA_W + clog2(VEC_LEN).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  beat available.
- in_ready  out  1  engine accepts a beat.
- in_values  in  LANES*DATA_W  lane k at bits [k*DATA_W +: DATA_W].
- in_weights  in  LANES*DATA_W  same packing as in_values.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- out_data  out  DATA_W  signed result.
- out_sat  out  1  result was clipped by saturation.

## Operation
- Beat accepted on a rising edge with in_valid && in_ready.
- Pipeline, one register per stage:
  - S1: LANES signed products, each 2*DATA_W wide.
  - S2: lane sum, sign-extended to ACC_W.
  - S3: accumulator.
  - S4: output register.
- Each stage carries a valid bit; bubbles (in_valid low) propagate and do not alter the accumulator.
- Beat counter 0..BEATS-1 counts accepted beats. The beat with counter = BEATS-1 is tagged last.
- The accumulator loads (not adds) the lane sum of beat 0 of each vector, so no clear cycle is needed.
- Result conversion: shift the accumulator arithmetically right by FRAC_W (floor, no rounding). Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. out_sat = 1 when clipping occurred.
- FSM states:
  - IDLE (counter = 0, in_ready = 1): first accepted beat → ACCUM.
  - ACCUM (in_ready = 1): acceptance of the last beat → DRAIN.
  - DRAIN (in_ready = 0): last beat reaches S4 → HOLD with out_valid = 1.
  - HOLD (in_ready = 0): out_valid && out_ready → IDLE and out_valid drops.
- BEATS = 1: IDLE goes directly to DRAIN.
- Reset mid-vector or mid-drain: partial sum discarded, counter = 0, state IDLE. No result is emitted.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_data = 0, out_sat = 0. Counter, accumulator and all stage valids = 0.
- Latency: final beat accepted on edge E → out_valid high after edge E+3.
- Throughput: BEATS + 4 cycles per vector with no stalls (784/16 → 53 cycles).
- In HOLD, out_data and out_sat are held stable until the handshake completes.
- out_valid never drops without out_ready.
- in_ready is combinational from state only, never from in_valid.

## Configuration
- DOT_RELU_EN defined: negative saturated results are replaced by 0 (ReLU fused). out_sat still reports negative clipping. The replacement adds no latency.
- DOT_RELU_EN undefined: signed result passed through unchanged.

## Test plan
All cases use defaults (784/16, Q8.8).
- Every value 0x0100, every weight 0x0010, in_valid held high → out_data = 0x3100 (12544), out_sat = 0. out_valid is seen 3 edges after the 49th beat.
- Every value 0x0100, every weight 0xFFF0 → out_data = 0xCF00, out_sat = 0. With DOT_RELU_EN → 0x0000.
- Every value and weight 0x0100 → out_data = 0x7FFF, out_sat = 1. Values 0xFF00 with weights 0x0100 → 0x8000, out_sat = 1.
- in_valid toggling every other cycle, plus out_ready low for 5 cycles in HOLD → same 0x3100. out_data stable and in_ready = 0 throughout the hold. IDLE is re-entered on the first edge with out_ready high.
- reset pulsed after beat 20, then a full vector of 0x0100 × 0x0010 → exactly one result, 0x3100. No residue from the partial vector.
- Two back-to-back vectors with different data (second: values 0x0200, weights 0x0010 → 0x6200) → second result correct. This proves the beat-0 accumulator load.
